conv_weight_buffer_pp: RTL and testbench
========================================

Name: conv_weight_buffer_pp

Overview:
- Parametrised successor to the fixed single-ROM conv weight source.
- Streams one tap per cycle to NUM_CH parallel conv lanes from a runtime-writable, double-banked (ping-pong) weight store.
- The host fills the shadow bank while the active bank streams, then swaps banks.
- Sits between the host/DMA weight loader and the conv kernel array; it is sequenced by the conv controller's current_state.

Parameters:
- DATA_WIDTH, 32, width of one weight/bias word.
- NUM_CH, 4, parallel output lanes; all lanes get the same tap index.
- KERNEL_SIZE, 3, kernel edge. TAPS = KERNEL_SIZE*KERNEL_SIZE+1 (last tap is bias).
- NUM_KERNEL, 4, kernel sets per bank, selectable at load time.
- Localparams: TAP_W = clog2(TAPS), KSEL_W = clog2(NUM_KERNEL), WADDR_W = clog2(NUM_KERNEL*TAPS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- current_state  in  3  conv controller state (STATE_* encodings from shared param file).
- i_kernel_sel  in  KSEL_W  kernel set; latched on LOAD/PRELOAD.
- i_wr_en  in  1  write strobe into shadow bank.
- i_wr_addr  in  WADDR_W  shadow-bank entry = kernel*TAPS + tap.
- i_wr_data  in  NUM_CH*DATA_WIDTH  one tap, all lanes (lane0 in LSBs).
- i_swap  in  1  request active/shadow bank exchange (pulse).
- o_weight  out  NUM_CH*DATA_WIDTH  registered tap data.
- o_valid  out  1  o_weight carries a tap this cycle.
- o_is_bias  out  1  o_weight is the bias tap.
- o_active_bank  out  1  bank currently streaming.
- o_swap_pending  out  1  swap requested, not yet applied.

Behaviour:
- Reset: o_weight=0, o_valid=0, o_is_bias=0, o_active_bank=0, o_swap_pending=0, tap counter=0, latched kernel=0. Memory contents are not reset.
- Tap counter:
  - LOAD or PRELOAD: counter<=0 and kernel_q<=i_kernel_sel.
  - SHIFT or BIAS: counter increments; at TAPS-1 it wraps to 0.
  - Any other state: counter holds.
- Read address = kernel_q*TAPS + counter, from the active bank, combinational read.
- Output, latency 1:
  - In cycle t with state SHIFT/BIAS: cycle t+1 has o_weight = mem[active][addr_t] and o_valid=1.
  - o_is_bias=1 iff counter_t == TAPS-1.
  - Other states: o_weight<=0, o_valid<=0, o_is_bias<=0.
- Writes:
  - Always target bank ~o_active_bank. Never modify the streaming bank.
  - Write with i_wr_addr >= NUM_KERNEL*TAPS is dropped silently.
  - Write and read of the same shadow address cannot conflict (different banks).
- Swap:
  - i_swap while state not SHIFT/BIAS: o_active_bank toggles next edge, and counter<=0.
  - i_swap during SHIFT/BIAS: o_swap_pending<=1. Applied on the first edge where state is not SHIFT/BIAS, which also clears pending.
  - Extra i_swap while pending: ignored (no double toggle).
  - i_wr_en and a swap applied in the same cycle: the write lands in the pre-swap shadow bank, which becomes active.
- Mid-stream reset: all outputs and pending state return to reset values immediately. Bank contents are retained, so a post-reset stream from bank 0 reads the existing data.
- Kernel select changes outside LOAD/PRELOAD have no effect.

Decomposition:
- Shared conv param file holds STATE_IDLE/PRELOAD/LOAD/SHIFT/BIAS encodings and global DATA_WIDTH. TAPS/width localparams are computed in-module.
- One sub-module, conv_weight_bank_ram: 2 x NUM_KERNEL*TAPS entries, one sync write port (bank, addr), one async read port (bank, addr).
- The top holds the counter, swap/pending logic and output register.

Test Plan:
- Directed scenarios use KERNEL_SIZE=3, TAPS=10, NUM_CH=4.
- Reset then PRELOAD, 10 cycles SHIFT, bank0 kernel0 tap n = {4{n}}:
  - o_weight = {4{0}}..{4{9}} on cycles 1..10, o_valid=1.
  - o_is_bias=1 only on the 10th.
  - 11th SHIFT returns {4{0}} (wrap).
- LOAD with i_kernel_sel=2, then SHIFT: first output = entry 20. Change i_kernel_sel to 1 mid-stream: entry sequence 21,22,… is unaffected.
- Fill bank1 during streaming of bank0; pulse i_swap during SHIFT:
  - o_swap_pending=1 and o_active_bank stays 0 until state goes IDLE.
  - Next edge: o_active_bank=1, pending=0, and the next stream reads the bank1 data.
- i_swap in IDLE with simultaneous i_wr_en addr 0 data X: o_active_bank=1, and the first subsequent tap reads X.
- Write to addr 40 (out of range): no entry changes (readback of all 40 entries unchanged).
- Assert rst mid-SHIFT with pending swap: o_weight=0, o_valid=0, pending=0, o_active_bank=0 asynchronously. Previously written bank0 data is still read back afterwards.

Source files
------------

// File: rtl/conv_weight_buffer_pp_pkg.sv
// Shared conv-controller encodings and the global word width used by the
// weight buffer and its bank RAM.
package conv_weight_buffer_pp_pkg;

  localparam int CONV_DATA_WIDTH = 32;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_PRELOAD = 3'd1;
  localparam logic [2:0] STATE_LOAD    = 3'd2;
  localparam logic [2:0] STATE_SHIFT   = 3'd3;
  localparam logic [2:0] STATE_BIAS    = 3'd4;

  // True in the states that consume one tap per cycle.
  function automatic logic is_streaming(input logic [2:0] st);
    return (st == STATE_SHIFT) || (st == STATE_BIAS);
  endfunction

  // True in the states that restart the tap sequence and latch a kernel set.
  function automatic logic is_loading(input logic [2:0] st);
    return (st == STATE_LOAD) || (st == STATE_PRELOAD);
  endfunction

endpackage

// File: rtl/conv_weight_bank_ram.sv
// Two-bank weight store: one synchronous write port and one asynchronous
// read port, each addressed by (bank, entry). Contents are never reset.
module conv_weight_bank_ram #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 40,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [2][DEPTH];

  // Synchronous write; entries beyond DEPTH are ignored.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem_q[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Asynchronous read; addresses beyond DEPTH return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < DEPTH) begin
      rd_data = mem_q[rd_bank][rd_addr];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/conv_weight_buffer_pp.sv
// Ping-pong conv weight source: streams one tap per cycle from the active bank
// while the host fills the shadow bank, and exchanges the banks on request
// once the current stream has left SHIFT/BIAS.
module conv_weight_buffer_pp
  import conv_weight_buffer_pp_pkg::*;
#(
  parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
  parameter int NUM_CH      = 4,
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_KERNEL  = 4,
  localparam int TAPS    = KERNEL_SIZE * KERNEL_SIZE + 1,
  localparam int TAP_W   = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int KSEL_W  = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1,
  localparam int WADDR_W = $clog2(NUM_KERNEL * TAPS),
  localparam int WORD_W  = NUM_CH * DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         current_state,
  input  logic [KSEL_W-1:0]  i_kernel_sel,
  input  logic               i_wr_en,
  input  logic [WADDR_W-1:0] i_wr_addr,
  input  logic [WORD_W-1:0]  i_wr_data,
  input  logic               i_swap,
  output logic [WORD_W-1:0]  o_weight,
  output logic               o_valid,
  output logic               o_is_bias,
  output logic               o_active_bank,
  output logic               o_swap_pending
);

  localparam int DEPTH = NUM_KERNEL * TAPS;

  logic [TAP_W-1:0]   counter_q, counter_d;
  logic [KSEL_W-1:0]  kernel_q, kernel_d;
  logic [WORD_W-1:0]  weight_q, weight_d;
  logic               valid_q, valid_d;
  logic               is_bias_q, is_bias_d;
  logic               active_q, active_d;
  logic               pending_q, pending_d;

  logic               streaming_s;
  logic               loading_s;
  logic               swap_apply_s;
  logic               last_tap_s;
  logic               wr_ok_s;
  logic [WADDR_W-1:0] rd_addr_s;
  logic [WORD_W-1:0]  rd_data_s;

  // Decode controller state, swap timing, write legality and read address.
  always_comb begin
    streaming_s  = is_streaming(current_state);
    loading_s    = is_loading(current_state);
    swap_apply_s = !streaming_s && (i_swap || pending_q);
    last_tap_s   = (counter_q == TAP_W'(TAPS - 1));
    wr_ok_s      = i_wr_en && (int'(i_wr_addr) < DEPTH);
    rd_addr_s    = WADDR_W'(kernel_q) * WADDR_W'(TAPS) + WADDR_W'(counter_q);
  end

  // Writes always go to the bank that is not streaming, so reads never collide.
  conv_weight_bank_ram #(
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (WADDR_W)
  ) u_bank_ram (
    .clk     (clk),
    .wr_en   (wr_ok_s),
    .wr_bank (~active_q),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_bank (active_q),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state for tap counter, kernel latch, bank select, swap pending and outputs.
  always_comb begin
    counter_d = counter_q;
    kernel_d  = kernel_q;
    if (loading_s) begin
      counter_d = '0;
      kernel_d  = i_kernel_sel;
    end else if (swap_apply_s) begin
      counter_d = '0;
    end else if (streaming_s) begin
      counter_d = last_tap_s ? '0 : counter_q + TAP_W'(1);
    end else begin
      counter_d = counter_q;
    end

    // A swap requested mid-stream waits; repeat requests collapse into one.
    if (streaming_s) begin
      pending_d = pending_q | i_swap;
    end else begin
      pending_d = 1'b0;
    end

    if (swap_apply_s) begin
      active_d = ~active_q;
    end else begin
      active_d = active_q;
    end

    if (streaming_s) begin
      weight_d  = rd_data_s;
      valid_d   = 1'b1;
      is_bias_d = last_tap_s;
    end else begin
      weight_d  = '0;
      valid_d   = 1'b0;
      is_bias_d = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q <= '0;
      kernel_q  <= '0;
      weight_q  <= '0;
      valid_q   <= 1'b0;
      is_bias_q <= 1'b0;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      counter_q <= counter_d;
      kernel_q  <= kernel_d;
      weight_q  <= weight_d;
      valid_q   <= valid_d;
      is_bias_q <= is_bias_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign o_weight       = weight_q;
  assign o_valid        = valid_q;
  assign o_is_bias      = is_bias_q;
  assign o_active_bank  = active_q;
  assign o_swap_pending = pending_q;

endmodule

// File: tb/tb_conv_weight_buffer_pp.sv
// Self-checking bench for conv_weight_buffer_pp: expected taps are pushed to a
// scoreboard when SHIFT/BIAS is driven and popped when the output arrives.
module tb_conv_weight_buffer_pp;
  import conv_weight_buffer_pp_pkg::*;

  localparam int WORD_W = 128;
  localparam int DEPTH  = 40;

  typedef struct {
    logic [WORD_W-1:0] w;
    logic              b;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [2:0]        current_state;
  logic [1:0]        i_kernel_sel;
  logic              i_wr_en;
  logic [5:0]        i_wr_addr;
  logic [WORD_W-1:0] i_wr_data;
  logic              i_swap;
  logic [WORD_W-1:0] o_weight;
  logic              o_valid;
  logic              o_is_bias;
  logic              o_active_bank;
  logic              o_swap_pending;

  logic [WORD_W-1:0] mem_model [2][DEPTH];
  logic              bench_active;
  exp_t              sb[$];
  int                n_checks;
  int                n_errors;

  conv_weight_buffer_pp #(
    .DATA_WIDTH  (32),
    .NUM_CH      (4),
    .KERNEL_SIZE (3),
    .NUM_KERNEL  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .current_state  (current_state),
    .i_kernel_sel   (i_kernel_sel),
    .i_wr_en        (i_wr_en),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .i_swap         (i_swap),
    .o_weight       (o_weight),
    .o_valid        (o_valid),
    .o_is_bias      (o_is_bias),
    .o_active_bank  (o_active_bank),
    .o_swap_pending (o_swap_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] rep(input int v);
    logic [31:0] w;
    w = 32'(v);
    return {4{w}};
  endfunction

  // Drive one cycle, then check valid and pop the scoreboard if a tap is due.
  task automatic cyc(input logic [2:0] st, input logic [1:0] sel, input logic we,
                     input logic [5:0] wa, input logic [WORD_W-1:0] wd, input logic sw);
    logic exp_v;
    exp_t e;
    current_state = st;
    i_kernel_sel  = sel;
    i_wr_en       = we;
    i_wr_addr     = wa;
    i_wr_data     = wd;
    i_swap        = sw;
    if (we && !rst && (int'(wa) < DEPTH)) mem_model[!bench_active][wa] = wd;
    exp_v = ((st == STATE_SHIFT) || (st == STATE_BIAS)) && !rst;
    @(posedge clk);
    #1;
    chk("valid", o_valid, exp_v);
    if (exp_v) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("weight", o_weight, e.w);
        chk("is_bias", o_is_bias, e.b);
      end
    end else begin
      chk("idle_weight", o_weight, '0);
    end
    i_wr_en = 1'b0;
    i_swap  = 1'b0;
  endtask

  task automatic tap(input logic [2:0] st, input logic [1:0] sel, input int addr, input logic bias,
                     input logic we = 1'b0, input logic [5:0] wa = 6'd0,
                     input logic [WORD_W-1:0] wd = '0, input logic sw = 1'b0);
    exp_t e;
    e.w = mem_model[bench_active][addr];
    e.b = bias;
    sb.push_back(e);
    cyc(st, sel, we, wa, wd, sw);
  endtask

  // PRELOAD kernel k then stream its ten taps, bias on the last.
  task automatic stream(input logic [1:0] k);
    cyc(STATE_PRELOAD, k, 1'b0, 6'd0, '0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      tap((n == 9) ? STATE_BIAS : STATE_SHIFT, k, int'(k) * 10 + n, n == 9);
    end
  endtask

  initial begin
    logic [WORD_W-1:0] xval;
    n_checks = 0;
    n_errors = 0;
    bench_active = 1'b0;
    rst = 1'b1;
    current_state = STATE_IDLE;
    i_kernel_sel = 2'd0;
    i_wr_en = 1'b0;
    i_wr_addr = 6'd0;
    i_wr_data = '0;
    i_swap = 1'b0;
    xval = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_weight", o_weight, '0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_bias", o_is_bias, 1'b0);
    chk("rst_bank", o_active_bank, 1'b0);
    chk("rst_pending", o_swap_pending, 1'b0);
    rst = 1'b0;

    // Fill bank1, swap, fill bank0 with {4{n}}, swap back
    for (int a = 0; a < DEPTH; a++) cyc(STATE_IDLE, 2'd0, 1'b1, 6'(a), rep(256 + a), 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b1);
    bench_active = 1'b1;
    chk("fill_swap1", o_active_bank, 1'b1);
    for (int a = 0; a < DEPTH; a++) cyc(STATE_IDLE, 2'd0, 1'b1, 6'(a), rep(a), 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b1);
    bench_active = 1'b0;
    chk("fill_swap0", o_active_bank, 1'b0);

    // Kernel 0 stream of 11 SHIFTs, wrapping on the 11th
    cyc(STATE_PRELOAD, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    for (int n = 0; n < 11; n++) tap(STATE_SHIFT, 2'd0, n % 10, (n % 10) == 9);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);

    // LOAD kernel 2; changing the select mid-stream has no effect
    cyc(STATE_LOAD, 2'd2, 1'b0, 6'd0, '0, 1'b0);
    for (int n = 0; n < 10; n++)
      tap((n == 9) ? STATE_BIAS : STATE_SHIFT, (n >= 3) ? 2'd1 : 2'd2, 20 + n, n == 9);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);

    // Fill bank1 while bank0 streams; swap requested mid-stream stays pending
    cyc(STATE_LOAD, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      tap((n == 9) ? STATE_BIAS : STATE_SHIFT, 2'd0, n, n == 9,
          1'b1, 6'(n), rep(512 + n), (n == 4) || (n == 7));
      if (n >= 4) begin
        chk("pend_stream", o_swap_pending, 1'b1);
        chk("bank_hold", o_active_bank, 1'b0);
      end
    end
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    bench_active = 1'b1;
    chk("swap_applied", o_active_bank, 1'b1);
    chk("pend_cleared", o_swap_pending, 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    chk("no_double_toggle", o_active_bank, 1'b1);
    stream(2'd0);
    for (int n = 0; n < 3; n++) tap(STATE_SHIFT, 2'd0, n, 1'b0);

    // Swap in IDLE with simultaneous write: write lands in the bank that becomes active
    cyc(STATE_IDLE, 2'd0, 1'b1, 6'd0, xval, 1'b1);
    bench_active = 1'b0;
    chk("idle_swap_bank", o_active_bank, 1'b0);
    chk("idle_swap_pend", o_swap_pending, 1'b0);
    tap(STATE_SHIFT, 2'd0, 0, 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);

    // Out-of-range write is dropped; read back all 40 entries of the shadow bank
    cyc(STATE_IDLE, 2'd0, 1'b1, 6'd40, {4{32'hBADBAD00}}, 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b1, 6'd63, {4{32'hBADBAD01}}, 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b1);
    bench_active = 1'b1;
    chk("oor_swap", o_active_bank, 1'b1);
    for (int k = 0; k < 4; k++) stream(2'(k));
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b1);
    bench_active = 1'b0;
    chk("oor_swap_back", o_active_bank, 1'b0);

    // Asynchronous reset mid-stream with a pending swap
    cyc(STATE_PRELOAD, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    tap(STATE_SHIFT, 2'd0, 0, 1'b0);
    tap(STATE_SHIFT, 2'd0, 1, 1'b0, 1'b0, 6'd0, '0, 1'b1);
    tap(STATE_SHIFT, 2'd0, 2, 1'b0);
    chk("pre_rst_pend", o_swap_pending, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_weight", o_weight, '0);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_pending", o_swap_pending, 1'b0);
    chk("arst_bank", o_active_bank, 1'b0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    rst = 1'b0;
    stream(2'd0);
    cyc(STATE_IDLE, 2'd0, 1'b0, 6'd0, '0, 1'b0);
    chk("sb_drained", 32'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
